// File: rtl/result_commit.sv
// result_commit: write-back unit at the tail of the ALU result path.
// Buffers {result, dest} pairs in an in-order FIFO and retires the oldest
// entry into an internal register file on each cycle that commit_en allows.
// Two combinational read ports return committed state plus a pending flag
// that is set when any buffered entry targets the addressed register.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   in_valid/in_ready            result handshake (in_ready = !full)
//   in_result, in_dest           result payload and destination index
//   commit_en                    permits retirement this cycle
//   rd_{a,b}_addr                read port indices
//   rd_{a,b}_data                committed register contents (combinational)
//   rd_{a,b}_pend                a buffered entry targets that index
//   count                        number of buffered entries
//   commit_valid, commit_dest    registered retirement strobe and index
module result_commit #(
    parameter int unsigned size   = 1,
    parameter int unsigned addr_w = 2,
    parameter int unsigned depth  = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [size-1:0]          in_result,
    input  logic [addr_w-1:0]        in_dest,
    input  logic                     commit_en,
    input  logic [addr_w-1:0]        rd_a_addr,
    input  logic [addr_w-1:0]        rd_b_addr,
    output logic [size-1:0]          rd_a_data,
    output logic [size-1:0]          rd_b_data,
    output logic                     rd_a_pend,
    output logic                     rd_b_pend,
    output logic [$clog2(depth):0]   count,
    output logic                     commit_valid,
    output logic [addr_w-1:0]        commit_dest
);

    localparam int unsigned ptr_w = $clog2(depth);
    localparam int unsigned cnt_w = ptr_w + 1;
    localparam int unsigned nregs = 1 << addr_w;

    typedef struct packed {
        logic [addr_w-1:0] dest;
        logic [size-1:0]   data;
    } entry_t;

    entry_t             fifo [depth];
    logic [ptr_w-1:0]   wr_ptr;
    logic [ptr_w-1:0]   rd_ptr;
    logic [cnt_w-1:0]   count_q;
    logic [size-1:0]    regs [nregs];

    logic   full;
    logic   empty;
    logic   push;
    logic   pop;
    entry_t head;

    // Full blocks pushes even when a pop happens in the same cycle.
    assign full     = (count_q == cnt_w'(depth));
    assign empty    = (count_q == '0);
    assign push     = in_valid && !full;
    assign pop      = commit_en && !empty;
    assign head     = fifo[rd_ptr];
    assign in_ready = !full;
    assign count    = count_q;

    // FIFO storage; contents are only meaningful under count_q, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wr_ptr] <= '{dest: in_dest, data: in_result};
        end
    end

    // Pointers wrap naturally; count disambiguates full from empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ptr_w'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ptr_w'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + cnt_w'(1);
                2'b01:   count_q <= count_q - cnt_w'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Register file: retire the head entry unmodified.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < nregs; i++) begin
                regs[i] <= '0;
            end
        end else if (pop) begin
            regs[head.dest] <= head.data;
        end
    end

    // Retirement strobe, one cycle per retiring edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            commit_valid <= 1'b0;
            commit_dest  <= '0;
        end else begin
            commit_valid <= pop;
            if (pop) begin
                commit_dest <= head.dest;
            end
        end
    end

    // Read ports see committed state only; no bypass from the FIFO.
    assign rd_a_data = regs[rd_a_addr];
    assign rd_b_data = regs[rd_b_addr];

    // Pending flags: OR over occupied slots, walked from the head.
    always_comb begin
        logic [ptr_w-1:0] idx;
        rd_a_pend = 1'b0;
        rd_b_pend = 1'b0;
        idx       = '0;
        for (int unsigned i = 0; i < depth; i++) begin
            idx = rd_ptr + ptr_w'(i);
            if (cnt_w'(i) < count_q) begin
                if (fifo[idx].dest == rd_a_addr) begin
                    rd_a_pend = 1'b1;
                end
                if (fifo[idx].dest == rd_b_addr) begin
                    rd_b_pend = 1'b1;
                end
            end
        end
    end

endmodule
